// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the single-port SRAM bus initiator.
package mem_bus_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_LEN_WIDTH  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_SETUP = 3'd2,
    RD_DATA  = 3'd3,
    TURN     = 3'd4
  } state_t;

endpackage

// File: rtl/memory_bus_master.sv
// Burst initiator for a single-port synchronous SRAM: sequences cs/we/oe/address,
// drives write data onto the shared bus and returns read data as a valid/ready stream.
module memory_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_beats_left;
  logic                  r_dir;
  logic                  w_req_fire;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_last_beat;

  assign w_last_beat = (r_beats_left == LEN_WIDTH'(0));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, handshakes and memory strobes
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    mem_cs       = 1'b0;
    mem_we       = 1'b0;
    mem_oe       = 1'b0;
    w_req_fire   = 1'b0;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready  = ~rst;
        w_req_fire = req_valid & ~rst;
        if (w_req_fire) begin
          w_next_state = req_write ? WRITE : RD_SETUP;
        end
      end
      WRITE: begin
        wr_ready  = 1'b1;
        w_wr_fire = wr_valid;
        mem_cs    = wr_valid;
        // Write strobe is interlocked with the latched direction of the command
        mem_we    = wr_valid & r_dir;
        if (wr_valid && w_last_beat) begin
          w_next_state = IDLE;
        end
      end
      RD_SETUP: begin
        mem_cs       = 1'b1;
        mem_oe       = 1'b1;
        w_next_state = RD_DATA;
      end
      RD_DATA: begin
        mem_cs    = 1'b1;
        mem_oe    = 1'b1;
        rd_valid  = 1'b1;
        rd_last   = w_last_beat;
        w_rd_fire = rd_ready;
        if (rd_ready) begin
          w_next_state = w_last_beat ? TURN : RD_SETUP;
        end
      end
      TURN: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address and beat counters; the address wraps modulo the memory size
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_beats_left <= '0;
      r_dir        <= 1'b0;
    end else if (w_req_fire) begin
      r_addr       <= req_addr;
      r_beats_left <= req_len;
      r_dir        <= req_write;
    end else if (w_wr_fire || (w_rd_fire && !w_last_beat)) begin
      r_addr <= ADDR_WIDTH'(r_addr + ADDR_WIDTH'(1));
      if (!w_last_beat) begin
        r_beats_left <= LEN_WIDTH'(r_beats_left - LEN_WIDTH'(1));
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign mem_address = r_addr;
  assign mem_data    = mem_we ? wr_data : {DATA_WIDTH{1'bz}};
  assign rd_data     = mem_data;

endmodule

// File: tb/tb_memory_bus_master.sv
// Self-checking bench: SRAM model on the bus, word-level reference memory,
// directed table, hand-written corner sequences and randomized bursts.
module tb_memory_bus_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic [9:0]  mem_address;
  wire  [15:0] mem_data;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;

  memory_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_address(mem_address), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model
  logic [15:0] sram [1024];
  logic [15:0] sram_q;
  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_address] <= mem_data;
    else if (mem_cs && mem_oe) sram_q <= sram[mem_address];
  end
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? sram_q : 16'hzzzz;

  int checks = 0;
  int errors = 0;
  logic [15:0] ref_mem [1024];
  logic [9:0]  wlog_a [$];
  logic [15:0] wlog_d [$];
  logic [15:0] gotd [$];
  bit          gotl [$];
  int          first_lat;
  logic        prev_oe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      wlog_a.push_back(mem_address);
      wlog_d.push_back(mem_data);
    end
  end

  // Bus safety: no we+oe overlap, no write drive right after a read cycle
  always @(negedge clk) begin
    if (!rst && busy) begin
      chk("we_oe_excl", {31'd0, mem_we & mem_oe}, 32'd0);
      if (mem_we) chk("turnaround", {31'd0, prev_oe}, 32'd0);
    end
    prev_oe = mem_oe;
  end

  task automatic send_req(input logic w, input logic [9:0] a, input logic [3:0] l);
    int cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    cnt = 0;
    while (!req_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) chk("req_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [9:0] a, input logic [3:0] l, input int gap_pct,
                             input bit seq_data);
    logic [15:0] d;
    int gaps;
    wlog_a.delete(); wlog_d.delete();
    send_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      gaps = 0;
      while (gaps < 3 && int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        wr_valid = 1'b0;
        gaps++;
      end
      @(negedge clk);
      d = seq_data ? 16'(i + 1) : 16'($urandom);
      wr_valid = 1'b1; wr_data = d;
      ref_mem[10'(int'(a) + i)] = d;
      chk("wr_ready", {31'd0, wr_ready}, 32'd1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_idle_after", {31'd0, busy}, 32'd0);
    chk("wr_strobe_cnt", wlog_a.size(), int'(l) + 1);
    for (int i = 0; i < wlog_a.size() && i <= int'(l); i++) begin
      chk("wr_addr", {22'd0, wlog_a[i]}, {22'd0, 10'(int'(a) + i)});
      chk("wr_data", {16'd0, wlog_d[i]}, {16'd0, ref_mem[10'(int'(a) + i)]});
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles on second beat
  task automatic read_burst(input logic [9:0] a, input logic [3:0] l, input int mode);
    int beat, cyc, stalls;
    bit rdy;
    gotd.delete(); gotl.delete();
    first_lat = -1; beat = 0; cyc = 0; stalls = 0;
    send_req(1'b0, a, l);
    while (beat <= int'(l) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rd_valid) begin
        if (first_lat < 0) first_lat = cyc;
        chk("rd_data", {16'd0, rd_data}, {16'd0, ref_mem[10'(int'(a) + beat)]});
        chk("rd_last", {31'd0, rd_last}, {31'd0, beat == int'(l)});
        case (mode)
          1: rdy = ($urandom_range(99) < 70);
          2: begin rdy = !(beat == 1 && stalls < 3); if (!rdy) stalls++; end
          default: rdy = 1'b1;
        endcase
        rd_ready = rdy;
        if (rdy) begin
          gotd.push_back(rd_data);
          gotl.push_back(rd_last);
          beat++;
        end
      end else begin
        rd_ready = 1'b0;
      end
    end
    if (cyc >= 200) chk("rd_timeout", 32'd1, 32'd0);
    @(negedge clk);
    rd_ready = 1'b0;
    chk("turn_busy", {31'd0, busy}, 32'd1);
    chk("turn_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    @(negedge clk);
    chk("idle_after_turn", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [8];
  logic [3:0] rlen;
  logic [9:0] raddr;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    prev_oe = 1'b0;

    vecs[0] = '{1'b1, 10'h012, 16'hBEEF};
    vecs[1] = '{1'b0, 10'h012, 16'hBEEF};
    vecs[2] = '{1'b1, 10'h3FF, 16'h1234};
    vecs[3] = '{1'b1, 10'h000, 16'hA5A5};
    vecs[4] = '{1'b0, 10'h3FF, 16'h1234};
    vecs[5] = '{1'b0, 10'h000, 16'hA5A5};
    vecs[6] = '{1'b1, 10'h155, 16'h0F0F};
    vecs[7] = '{1'b0, 10'h155, 16'h0F0F};

    // Reset state
    #13;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_outs", {26'd0, busy, wr_ready, rd_valid, mem_cs, mem_we, mem_oe}, 32'd0);
    chk("rst_addr", {22'd0, mem_address}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Directed single-beat table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        wlog_a.delete(); wlog_d.delete();
        send_req(1'b1, vecs[i].addr, 4'd0);
        @(negedge clk);
        wr_valid = 1'b1; wr_data = vecs[i].data;
        ref_mem[vecs[i].addr] = vecs[i].data;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("tbl_wr_cnt", wlog_a.size(), 1);
        if (wlog_a.size() > 0) chk("tbl_wr_data", {16'd0, wlog_d[0]}, {16'd0, vecs[i].data});
      end else begin
        read_burst(vecs[i].addr, 4'd0, 0);
        chk("tbl_rd_beats", gotd.size(), 1);
        if (gotd.size() > 0) begin
          chk("tbl_rd_data", {16'd0, gotd[0]}, {16'd0, vecs[i].data});
          chk("tbl_rd_last", {31'd0, gotl[0]}, 32'd1);
        end
        chk("tbl_rd_latency", first_lat, 2);
      end
    end

    // Write burst with gaps, then read back with a 3-cycle stall on beat 2
    write_burst(10'h100, 4'd3, 50, 1'b1);
    read_burst(10'h100, 4'd3, 2);
    chk("burst_beats", gotd.size(), 4);
    for (int i = 0; i < gotd.size() && i < 4; i++) begin
      chk("burst_data", {16'd0, gotd[i]}, i + 1);
      chk("burst_last", {31'd0, gotl[i]}, {31'd0, i == 3});
    end

    // Address wrap across the top of memory
    write_burst(10'h3FE, 4'd3, 0, 1'b0);
    if (wlog_a.size() == 4) begin
      chk("wrap_a0", {22'd0, wlog_a[0]}, 32'h3FE);
      chk("wrap_a1", {22'd0, wlog_a[1]}, 32'h3FF);
      chk("wrap_a2", {22'd0, wlog_a[2]}, 32'h000);
      chk("wrap_a3", {22'd0, wlog_a[3]}, 32'h001);
    end
    read_burst(10'h3FE, 4'd3, 1);

    // Reset in the middle of a read burst, on beat 2
    begin
      int cnt;
      send_req(1'b0, 10'h100, 4'd3);
      cnt = 0;
      @(negedge clk);
      while (!rd_valid && cnt < 10) begin @(negedge clk); cnt++; end
      chk("mid_beat1_valid", {31'd0, rd_valid}, 32'd1);
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      @(negedge clk);
      chk("mid_beat2_valid", {31'd0, rd_valid}, 32'd1);
      chk("mid_beat2_data", {16'd0, rd_data}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_strobes", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
      chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_addr", {22'd0, mem_address}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      read_burst(10'h012, 4'd0, 0);
      if (gotd.size() > 0) chk("post_rst_read", {16'd0, gotd[0]}, 32'hBEEF);
    end

    // Randomized bursts against the reference memory
    for (int n = 0; n < 30; n++) begin
      raddr = 10'($urandom);
      rlen  = 4'($urandom);
      if ($urandom_range(1) == 1) write_burst(raddr, rlen, 30, 1'b0);
      else read_burst(raddr, rlen, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
